bcd_conv_arbiter: RTL

Shares one combinational 8-bit binary-to-BCD converter (ADD4BIT) between `N_REQ` requesters. Each requester presents a byte with a valid/ready handshake. A round-robin arbiter picks one requester per cycle, the byte is converted, and the 10-bit BCD result is registered with the requester's index. The block sits between the byte producers (status and debug taps) and the shared display/report path, which drains results with its own valid/ready handshake.

---
 rtl/bcd_conv_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
// Shares one combinational binary-to-BCD converter among N_REQ byte requesters via a round-robin arbiter.
// Define BCD_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module bcd_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9:0]           out_bcd,
    output logic [ID_W-1:0]      out_id,
    output logic [15:0]          conv_count
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    logic [9:0]      bcd_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] last_gnt_q;
    logic [15:0]     count_q;

    logic [ID_W-1:0] win_d;
    logic            found_d;
    logic            can_accept;
    logic            accept;
    logic [7:0]      win_byte;
    logic [9:0]      bcd_d;

    // Shift-and-add-3; hundreds only ever reaches 2, so it needs no correction step.
    function automatic logic [9:0] bin2bcd(input logic [7:0] bin);
        logic [17:0] sh;
        sh = {10'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5) sh[11:8] = sh[11:8] + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            sh = sh << 1;
        end
        return sh[17:8];
    endfunction

    // Scan in reverse so the last hit is the first index in search order.
    always_comb begin
        int idx;
        idx     = 0;
        win_d   = '0;
        found_d = 1'b0;
`ifdef BCD_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_d   = ID_W'(i);
                found_d = 1'b1;
            end
        end
`else
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last_gnt_q) + off) % N_REQ;
            if (req_valid[idx]) begin
                win_d   = ID_W'(idx);
                found_d = 1'b1;
            end
        end
`endif
    end

    assign can_accept = rst_n && ((state_q == EMPTY) || out_ready);
    assign accept     = found_d && can_accept;
    assign win_byte   = req_data[int'(win_d)*8 +: 8];
    assign bcd_d      = bin2bcd(win_byte);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = accept && (win_d == ID_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            bcd_q      <= '0;
            id_q       <= '0;
            count_q    <= '0;
            last_gnt_q <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            state_q <= FULL;
            bcd_q   <= bcd_d;
            id_q    <= win_d;
`ifndef BCD_ARB_FIXED_PRIO_EN
            last_gnt_q <= win_d;
`endif
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end else if ((state_q == FULL) && out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_bcd    = bcd_q;
    assign out_id     = id_q;
    assign conv_count = count_q;
endmodule
